// File: rtl/dlx_load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and data memory (slave).
// req/ack handshake; address, enables and write data are held while req is high.
interface dlx_load_store_unit_if #(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_ADDR_WIDTH = 32
);
  localparam int NB = DATA_WIDTH / 8;

  logic                       data_req_out;
  logic                       data_we_out;
  logic [DATA_ADDR_WIDTH-1:0] data_addr_out;
  logic [NB-1:0]              data_be_out;
  logic [DATA_WIDTH-1:0]      data_write_out;
  logic [DATA_WIDTH-1:0]      data_read_in;
  logic                       data_ack_in;

  modport master (
    output data_req_out, data_we_out, data_addr_out, data_be_out, data_write_out,
    input  data_read_in, data_ack_in
  );

  modport slave (
    input  data_req_out, data_we_out, data_addr_out, data_be_out, data_write_out,
    output data_read_in, data_ack_in
  );
endinterface

// File: rtl/dlx_load_store_unit.sv
// MEM-stage load/store unit: sized, byte-enabled accesses over a req/ack bus,
// with stall generation, misalignment detection and a request timeout.
module dlx_load_store_unit #(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_ADDR_WIDTH = 32,
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ex_mem_valid_in,
  input  logic                       ex_mem_rd_en_in,
  input  logic                       ex_mem_wr_en_in,
  input  logic [1:0]                 ex_mem_size_in,
  input  logic                       ex_mem_signed_in,
  input  logic [DATA_ADDR_WIDTH-1:0] ex_mem_addr_in,
  input  logic [DATA_WIDTH-1:0]      ex_mem_wr_data_in,
  input  logic [REG_ADDR_WIDTH-1:0]  ex_mem_reg_wr_addr_in,
  input  logic                       flush_in,
  output logic                       stall_out,
  output logic                       load_valid_out,
  output logic [DATA_WIDTH-1:0]      load_data_out,
  output logic [REG_ADDR_WIDTH-1:0]  load_reg_addr_out,
  output logic                       err_out,
  dlx_load_store_unit_if.master      mem
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 2);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]                 state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       is_load_q, is_load_d;
  logic [1:0]                 size_q, size_d;
  logic                       sgn_q, sgn_d;
  logic [OW-1:0]              off_q, off_d;
  logic                       err_q, err_d;
  logic [REG_ADDR_WIDTH-1:0]  reg_q, reg_d;
  logic [DATA_WIDTH-1:0]      ldata_q, ldata_d;
  logic                       req_q, req_d;
  logic                       we_q, we_d;
  logic [DATA_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [NB-1:0]              be_q, be_d;
  logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;

  logic                  access, bad;
  logic [OW-1:0]         off_in;
  logic [NB-1:0]         be_c;
  logic [DATA_WIDTH-1:0] repl_c, rsh, mask, ext;
  logic                  sbit;

  assign access = ex_mem_valid_in & (ex_mem_rd_en_in | ex_mem_wr_en_in) & ~flush_in;
  assign off_in = ex_mem_addr_in[OW-1:0];

  // Decode of the incoming access: alignment, byte enables, lane replication.
  always_comb begin
    be_c   = '1;
    repl_c = ex_mem_wr_data_in;
    bad    = 1'b0;
    case (ex_mem_size_in)
      2'b00: begin
        be_c   = NB'(1) << off_in;
        repl_c = {(DATA_WIDTH/8){ex_mem_wr_data_in[7:0]}};
      end
      2'b01: begin
        be_c   = NB'(3) << off_in;
        repl_c = {(DATA_WIDTH/16){ex_mem_wr_data_in[15:0]}};
        bad    = ex_mem_addr_in[0];
      end
      2'b10: begin
        be_c   = NB'(4'hF) << off_in;
        repl_c = {(DATA_WIDTH/32){ex_mem_wr_data_in[31:0]}};
        bad    = |ex_mem_addr_in[1:0];
      end
      default: bad = (DATA_WIDTH == 32) || (|ex_mem_addr_in[2:0]);
    endcase
  end

  // Load extraction: shift the addressed lanes down, then extend above the mask.
  always_comb begin
    rsh  = mem.data_read_in >> {off_q, 3'b000};
    mask = '1;
    sbit = 1'b0;
    case (size_q)
      2'b00:   begin mask = DATA_WIDTH'(8'hFF);         sbit = rsh[7];  end
      2'b01:   begin mask = DATA_WIDTH'(16'hFFFF);      sbit = rsh[15]; end
      2'b10:   begin mask = DATA_WIDTH'(32'hFFFF_FFFF); sbit = rsh[31]; end
      default: ;
    endcase
    ext = (rsh & mask) | ({DATA_WIDTH{sgn_q & sbit}} & ~mask);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_load_d = is_load_q;
    size_d    = size_q;
    sgn_d     = sgn_q;
    off_d     = off_q;
    err_d     = err_q;
    reg_d     = reg_q;
    ldata_d   = ldata_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    case (state_q)
      IDLE: if (access) begin
        is_load_d = ex_mem_rd_en_in;
        size_d    = ex_mem_size_in;
        sgn_d     = ex_mem_signed_in;
        off_d     = off_in;
        reg_d     = ex_mem_reg_wr_addr_in;
        err_d     = bad;
        ldata_d   = '0;
        cnt_d     = '0;
        state_d   = bad ? RESP : REQ;
        if (!bad) begin
          req_d   = 1'b1;
          we_d    = ex_mem_wr_en_in;
          addr_d  = {ex_mem_addr_in[DATA_ADDR_WIDTH-1:OW], {OW{1'b0}}};
          be_d    = ex_mem_wr_en_in ? be_c : '0;
          wdata_d = ex_mem_wr_en_in ? repl_c : '0;
        end
      end
      REQ: begin
        if (mem.data_ack_in) begin
          ldata_d = is_load_q ? ext : '0;
          state_d = RESP;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES))) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        if (state_d == RESP) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = '0;
          be_d    = '0;
          wdata_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        err_d   = 1'b0;
        ldata_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      is_load_q <= 1'b0;
      size_q    <= '0;
      sgn_q     <= 1'b0;
      off_q     <= '0;
      err_q     <= 1'b0;
      reg_q     <= '0;
      ldata_q   <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_load_q <= is_load_d;
      size_q    <= size_d;
      sgn_q     <= sgn_d;
      off_q     <= off_d;
      err_q     <= err_d;
      reg_q     <= reg_d;
      ldata_q   <= ldata_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
    end
  end

  // rst_n gating keeps stall low while reset is held, even with a valid access.
  assign stall_out         = rst_n & (((state_q == IDLE) & access) | (state_q == REQ));
  assign load_valid_out    = (state_q == RESP) & is_load_q;
  assign load_data_out     = ldata_q;
  assign load_reg_addr_out = load_valid_out ? reg_q : '0;
  assign err_out           = (state_q == RESP) & err_q;

  assign mem.data_req_out   = req_q;
  assign mem.data_we_out    = we_q;
  assign mem.data_addr_out  = addr_q;
  assign mem.data_be_out    = be_q;
  assign mem.data_write_out = wdata_q;
endmodule

// File: tb/tb_dlx_load_store_unit.sv
// Directed bench: instance a (TIMEOUT_CYCLES=4) and instance b (timeout disabled)
// share all inputs except valid; expected values are hand-computed constants.
module tb_dlx_load_store_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0, rd = 1'b0, wr = 1'b0, sgn = 1'b0, flush = 1'b0, sel_b = 1'b0;
  logic [1:0]  size = '0;
  logic [31:0] addr = '0, wdata = '0, rdata = '0;
  logic [4:0]  rega = '0;
  logic        ack = 1'b0;

  logic        stall_a, lv_a, err_a, stall_b, lv_b, err_b;
  logic [31:0] ld_a, ld_b;
  logic [4:0]  lr_a, lr_b;

  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  dlx_load_store_unit_if #(.DATA_WIDTH(32), .DATA_ADDR_WIDTH(32)) mem_a ();
  dlx_load_store_unit_if #(.DATA_WIDTH(32), .DATA_ADDR_WIDTH(32)) mem_b ();
  assign mem_a.data_ack_in  = ack;
  assign mem_a.data_read_in = rdata;
  assign mem_b.data_ack_in  = ack;
  assign mem_b.data_read_in = rdata;

  dlx_load_store_unit #(.TIMEOUT_CYCLES(4)) u_a (
    .clk(clk), .rst_n(rst_n), .ex_mem_valid_in(valid & ~sel_b), .ex_mem_rd_en_in(rd),
    .ex_mem_wr_en_in(wr), .ex_mem_size_in(size), .ex_mem_signed_in(sgn),
    .ex_mem_addr_in(addr), .ex_mem_wr_data_in(wdata), .ex_mem_reg_wr_addr_in(rega),
    .flush_in(flush), .stall_out(stall_a), .load_valid_out(lv_a), .load_data_out(ld_a),
    .load_reg_addr_out(lr_a), .err_out(err_a), .mem(mem_a.master));

  dlx_load_store_unit #(.TIMEOUT_CYCLES(0)) u_b (
    .clk(clk), .rst_n(rst_n), .ex_mem_valid_in(valid & sel_b), .ex_mem_rd_en_in(rd),
    .ex_mem_wr_en_in(wr), .ex_mem_size_in(size), .ex_mem_signed_in(sgn),
    .ex_mem_addr_in(addr), .ex_mem_wr_data_in(wdata), .ex_mem_reg_wr_addr_in(rega),
    .flush_in(flush), .stall_out(stall_b), .load_valid_out(lv_b), .load_data_out(ld_b),
    .load_reg_addr_out(lr_b), .err_out(err_b), .mem(mem_b.master));

  wire        o_stall = sel_b ? stall_b : stall_a;
  wire        o_lv    = sel_b ? lv_b : lv_a;
  wire        o_err   = sel_b ? err_b : err_a;
  wire [31:0] o_ld    = sel_b ? ld_b : ld_a;
  wire [4:0]  o_lr    = sel_b ? lr_b : lr_a;
  wire        o_req   = sel_b ? mem_b.data_req_out : mem_a.data_req_out;
  wire        o_we    = sel_b ? mem_b.data_we_out : mem_a.data_we_out;
  wire [31:0] o_addr  = sel_b ? mem_b.data_addr_out : mem_a.data_addr_out;
  wire [3:0]  o_be    = sel_b ? mem_b.data_be_out : mem_a.data_be_out;
  wire [31:0] o_wd    = sel_b ? mem_b.data_write_out : mem_a.data_write_out;

  int          n_stall, n_req;
  logic        r_we, r_lv, r_err, r_done;
  logic [31:0] r_addr, r_wd, r_ld;
  logic [3:0]  r_be;
  logic [4:0]  r_lr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One access: inputs presented after a rising edge, outputs sampled on falling
  // edges until the RESP cycle (stall low). ack_at = REQ cycle that sees ack, 0 = never.
  task automatic access(input logic b, input logic i_rd, input logic i_wr, input logic [1:0] i_sz,
                        input logic i_sgn, input logic [31:0] i_addr, input logic [31:0] i_wd,
                        input logic [4:0] i_reg, input int ack_at, input logic [31:0] i_rdata);
    @(posedge clk); #1;
    sel_b = b; rd = i_rd; wr = i_wr; size = i_sz; sgn = i_sgn;
    addr = i_addr; wdata = i_wd; rega = i_reg; valid = 1'b1;
    n_stall = 0; n_req = 0; r_we = 0; r_lv = 0; r_err = 0; r_done = 0;
    r_addr = '0; r_wd = '0; r_ld = '0; r_be = '0; r_lr = '0;
    for (int c = 0; c < 40 && !r_done; c++) begin
      @(negedge clk);
      if (o_stall) n_stall++;
      if (o_req) begin
        n_req++;
        if (n_req == 1) begin r_we = o_we; r_addr = o_addr; r_be = o_be; r_wd = o_wd; end
        if (n_req == ack_at) begin ack = 1'b1; rdata = i_rdata; end
      end
      if (o_lv || o_err) begin r_lv = o_lv; r_err = o_err; r_ld = o_ld; r_lr = o_lr; end
      if (!o_stall) r_done = 1'b1;
      @(posedge clk); #1;
      valid = 1'b0; ack = 1'b0;
    end
    chk("access_done", r_done, 1'b1);
    @(negedge clk);
    chk("pulse_clears", {o_lv, o_err}, 2'b00);
  endtask

  initial begin
    #12;
    chk("rst_stall", stall_a, 1'b0);
    chk("rst_req", mem_a.data_req_out, 1'b0);
    chk("rst_outs", {lv_a, err_a, ld_a, lr_a}, '0);
    @(negedge clk); rst_n = 1'b1;

    // word load, ack on first REQ cycle
    access(0, 1, 0, 2'b10, 0, 32'h100, 0, 5'd7, 1, 32'hDEADBEEF);
    chk("wl_stall", n_stall, 2);
    chk("wl_req", n_req, 1);
    chk("wl_addr", r_addr, 32'h100);
    chk("wl_we", r_we, 1'b0);
    chk("wl_lv", r_lv, 1'b1);
    chk("wl_data", r_ld, 32'hDEADBEEF);
    chk("wl_reg", r_lr, 5'd7);

    // signed / unsigned byte load from lane 3
    access(0, 1, 0, 2'b00, 1, 32'h103, 0, 5'd3, 1, 32'h80123456);
    chk("lbs_be", r_be, 4'b0000);
    chk("lbs_addr", r_addr, 32'h100);
    chk("lbs_data", r_ld, 32'hFFFFFF80);
    access(0, 1, 0, 2'b00, 0, 32'h103, 0, 5'd3, 1, 32'h80123456);
    chk("lbu_data", r_ld, 32'h00000080);

    // signed half load from upper half
    access(0, 1, 0, 2'b01, 1, 32'h102, 0, 5'd9, 1, 32'h80011234);
    chk("lhs_data", r_ld, 32'hFFFF8001);

    // half store to 0x202
    access(0, 0, 1, 2'b01, 0, 32'h202, 32'h0000ABCD, 5'd0, 1, 0);
    chk("sh_be", r_be, 4'b1100);
    chk("sh_wd", r_wd, 32'hABCDABCD);
    chk("sh_addr", r_addr, 32'h200);
    chk("sh_we", r_we, 1'b1);
    chk("sh_lv", r_lv, 1'b0);
    chk("sh_stall", n_stall, 2);

    // byte store to lane 1
    access(0, 0, 1, 2'b00, 0, 32'h101, 32'h1234565A, 5'd0, 1, 0);
    chk("sb_be", r_be, 4'b0010);
    chk("sb_wd", r_wd, 32'h5A5A5A5A);

    // misaligned word load
    access(0, 1, 0, 2'b10, 0, 32'h101, 0, 5'd4, 1, 32'hFFFFFFFF);
    chk("mis_req", n_req, 0);
    chk("mis_err", r_err, 1'b1);
    chk("mis_data", r_ld, 32'h0);
    chk("mis_stall", n_stall, 1);

    // doubleword is illegal at 32-bit width
    access(0, 1, 0, 2'b11, 0, 32'h100, 0, 5'd4, 1, 0);
    chk("dw_err", {r_err, 32'(n_req)}, {1'b1, 32'd0});

    // timeout: TIMEOUT_CYCLES=4, no ack
    access(0, 1, 0, 2'b10, 0, 32'h300, 0, 5'd5, 0, 0);
    chk("to_req", n_req, 5);
    chk("to_err", r_err, 1'b1);
    chk("to_stall", n_stall, 6);

    // timeout disabled, ack 3 cycles late
    access(1, 1, 0, 2'b10, 0, 32'h400, 0, 5'd6, 4, 32'h13572468);
    chk("late_req", n_req, 4);
    chk("late_err", r_err, 1'b0);
    chk("late_data", r_ld, 32'h13572468);
    chk("late_stall", n_stall, 5);

    // reset while in REQ
    @(posedge clk); #1;
    sel_b = 0; rd = 1; wr = 0; size = 2'b10; addr = 32'h500; valid = 1'b1;
    @(posedge clk); #1; valid = 1'b0;
    @(negedge clk);
    chk("mid_req_up", {o_req, o_stall}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_req", mem_a.data_req_out, 1'b0);
    chk("mid_rst_stall", stall_a, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    // flush in IDLE blocks a valid load
    flush = 1'b1;
    access(0, 1, 0, 2'b10, 0, 32'h100, 0, 5'd1, 1, 0);
    chk("fl_req", n_req, 0);
    chk("fl_stall", n_stall, 0);
    flush = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
